vx_operands_gather: RTL and testbench
=====================================

// Module: vx_operands_gather
// PURPOSE
//  Multi-lane successor to the single valid/data/ready operand channel: buffers operand packets from NUM_LANES
//  issue slices in per-lane FIFOs and merges them onto one dispatch channel. Uses round-robin arbitration.
//  Matrix instruction groups (group count field > 0) lock the arbiter to one lane until the group is fully issued.
//  Sits between the operand collectors and the dispatch stage.
// PARAMETERS
//  NUM_LANES   4    input channels (issue slices), >=1
//  DATA_WIDTH  512  packed operand packet width (bits)
//  DEPTH       4    entries per lane FIFO; power of 2, >=2
//  CNT_W       4    width of group-count field (matches 4-bit m_instr_cnt)
//  LANE_W      $clog2(NUM_LANES) (min 1), derived
// PORTS
//  clk         in   1                     clock
//  reset       in   1                     async, active-high
//  in_valid    in   NUM_LANES             per-lane packet valid
//  in_data     in   NUM_LANES*DATA_WIDTH  per-lane packet, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//  in_gcnt     in   NUM_LANES*CNT_W       per-lane packet: number of FOLLOWING packets in the same group (0 = single)
//  in_ready    out  NUM_LANES             per-lane accept
//  out_valid   out  1                     dispatch packet valid
//  out_data    out  DATA_WIDTH            dispatch packet
//  out_lane    out  LANE_W                source lane of out_data
//  out_ready   in   1                     dispatch accept
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-high.
//  - Reset (async assert, any cycle incl. mid-group): all FIFOs empty, state UNLOCKED, rr pointer=0, remaining=0,
//    hold=0, perf counters 0. Outputs: in_ready=all 1, out_valid=0, out_data=0, out_lane=0.
//  - Transfer rule: transfer occurs when valid&&ready on the same rising edge.
//  - Lane FIFO: push on in_valid[i]&&in_ready[i]; in_ready[i] = !full[i]. Full FIFO never accepts, even on a same-cycle pop.
//    Data and gcnt are stored together. No bypass: min latency in->out is 1 cycle.
//  - Flow control: out_data/out_lane come from the head of the granted lane. out_valid = granted head non-empty.
//    Pop on out_valid&&out_ready.
//  - Stability: while out_valid&&!out_ready, the grant is held (hold=1), so out_data/out_lane stay stable. No re-arbitration until fire.
//  - State UNLOCKED: grant the first non-empty lane searching from rr pointer upward, mod NUM_LANES.
//    On fire from lane k: if head gcnt=0, rr=k+1 mod N. If gcnt=G>0, go to LOCKED, lock_lane=k, remaining=G; rr unchanged.
//  - State LOCKED: grant only lock_lane. Other lanes never issue, even when lock_lane is empty; this gives out_valid=0 bubbles.
//    Each fire decrements remaining; gcnt of in-group packets is ignored.
//    On the fire where remaining 1->0: go to UNLOCKED, rr=lock_lane+1 mod N.
//  - Simultaneous push+pop on one lane: both occur; occupancy is unchanged; a non-full FIFO stays writable.
//  - Pointer wrap: FIFO rd/wr pointers are log2(DEPTH)+1 bits; full = MSBs differ and LSBs equal.
//  - NUM_LANES=1: arbiter degenerates; out_lane=0; locking still counts remaining.
// CONFIGURATION
//  VX_OPERANDS_GATHER_PERF_EN defined: adds output ports perf_stalls[31:0] (cycles with out_valid&&!out_ready) and
//  perf_bubbles[31:0] (LOCKED cycles with lock_lane empty while another lane is non-empty).
//  Both counters are saturating and reset to 0.
//  Undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  T1 reset: assert reset mid-LOCKED with lanes holding data -> same cycle out_valid=0, in_ready=all 1; after release, rr=0.
//  T2 round-robin: lanes 0..3 each push one gcnt=0 packet in the same cycle, out_ready=1 -> out_lane 0,1,2,3 on consecutive cycles.
//  T3 group lock: lane 2 pushes gcnt=2,A then B,C a few cycles late; lane 0 has data ->
//     out_lane=2 for A; bubbles until B,C arrive; lane 0 is not granted until C fires; then rr=3.
//  T4 backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_lane constant; perf_stalls=5 (PERF_EN).
//  T5 full: DEPTH=4; push 4 packets into lane 1 with out_ready=0 -> in_ready[1]=0.
//     One pop -> in_ready[1]=1 the next cycle; data order is preserved.
//  T6 random: all lanes random valid/gcnt 0..3, random out_ready, 10k cycles ->
//     scoreboard per-lane FIFO order; groups contiguous; no loss or duplication.

Source files
------------

// File: rtl/vx_operands_gather_if.sv
// ---------------------------------------------------------------------------
// vx_operands_gather_if
// Bundles the multi-lane operand intake and the single dispatch channel of
// vx_operands_gather.
//   in_valid  [NUM_LANES]             per-lane packet valid
//   in_data   [NUM_LANES*DATA_WIDTH]  per-lane packet, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_gcnt   [NUM_LANES*CNT_W]       per-lane count of following packets in the same group
//   in_ready  [NUM_LANES]             per-lane accept
//   out_valid / out_data / out_lane   dispatch packet and its source lane
//   out_ready                         dispatch accept
// Modports: master = operand collectors + dispatch stage side,
//           slave  = the gather block.
// ---------------------------------------------------------------------------
interface vx_operands_gather_if #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 512,
    parameter int CNT_W      = 4,
    parameter int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
);
    logic [NUM_LANES-1:0]            in_valid;
    logic [NUM_LANES*DATA_WIDTH-1:0] in_data;
    logic [NUM_LANES*CNT_W-1:0]      in_gcnt;
    logic [NUM_LANES-1:0]            in_ready;
    logic                            out_valid;
    logic [DATA_WIDTH-1:0]           out_data;
    logic [LANE_W-1:0]               out_lane;
    logic                            out_ready;

    modport master (
        output in_valid, in_data, in_gcnt, out_ready,
        input  in_ready, out_valid, out_data, out_lane
    );

    modport slave (
        input  in_valid, in_data, in_gcnt, out_ready,
        output in_ready, out_valid, out_data, out_lane
    );
endinterface

// File: rtl/vx_operands_gather.sv
// ---------------------------------------------------------------------------
// vx_operands_gather
// Buffers operand packets from NUM_LANES issue slices in per-lane FIFOs and
// merges them onto one dispatch channel with round-robin arbitration. A packet
// with a non-zero group count locks the arbiter onto its lane until the whole
// group (that packet plus gcnt followers) has been dispatched.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high
//   bus    vx_operands_gather_if.slave (lane intake + dispatch channel)
//   perf_stalls  [31:0]  (VX_OPERANDS_GATHER_PERF_EN only) saturating count of
//                        cycles with out_valid && !out_ready
//   perf_bubbles [31:0]  (VX_OPERANDS_GATHER_PERF_EN only) saturating count of
//                        locked cycles where the locked lane is empty while
//                        another lane holds data
// Optional feature macro: VX_OPERANDS_GATHER_PERF_EN.
// ---------------------------------------------------------------------------
module vx_operands_gather #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 4,
    parameter int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    vx_operands_gather_if.slave  bus
`ifdef VX_OPERANDS_GATHER_PERF_EN
    ,
    output logic [31:0]          perf_stalls,
    output logic [31:0]          perf_bubbles
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t            state_reg, state_next;
    logic [LANE_W-1:0] rr_reg, rr_next;
    logic [LANE_W-1:0] lock_lane_reg, lock_lane_next;
    logic [CNT_W-1:0]  remaining_reg, remaining_next;
    logic              hold_reg, hold_next;
    logic [LANE_W-1:0] grant_reg, grant_next;

    logic [NUM_LANES-1:0]  empty;
    logic [NUM_LANES-1:0]  full;
    logic [NUM_LANES-1:0]  push;
    logic [NUM_LANES-1:0]  pop;
    logic [DATA_WIDTH-1:0] head_data [NUM_LANES];
    logic [CNT_W-1:0]      head_gcnt [NUM_LANES];

    logic [LANE_W-1:0] search_lane;
    logic [LANE_W-1:0] grant;
    logic              out_valid;
    logic              fire;

    function automatic logic [LANE_W-1:0] next_lane(input logic [LANE_W-1:0] lane);
        if (int'(lane) >= NUM_LANES - 1)
            return '0;
        else
            return lane + LANE_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Per-lane FIFOs. Data and group count travel together. Pointers carry
    // one extra wrap bit so full and empty are distinguishable.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [CNT_W+DATA_WIDTH-1:0] mem [DEPTH];
            logic [AW:0]                 wr_ptr_reg;
            logic [AW:0]                 rd_ptr_reg;

            assign empty[gi] = (wr_ptr_reg == rd_ptr_reg);
            assign full[gi]  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                               (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
            // A full FIFO refuses the push even if the head pops this cycle.
            assign push[gi]  = bus.in_valid[gi] && !full[gi];
            assign pop[gi]   = fire && (grant == LANE_W'(gi));

            assign {head_gcnt[gi], head_data[gi]} = mem[rd_ptr_reg[AW-1:0]];

            always_ff @(posedge clk) begin
                if (push[gi])
                    mem[wr_ptr_reg[AW-1:0]] <= {bus.in_gcnt[gi*CNT_W +: CNT_W],
                                                bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH]};
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (push[gi])
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop[gi])
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign bus.in_ready = ~full;

    // ------------------------------------------------------------------
    // Round-robin search: first non-empty lane starting at rr_reg.
    // ------------------------------------------------------------------
    always_comb begin
        logic found;
        int   idx;
        search_lane = rr_reg;
        found       = 1'b0;
        idx         = 0;
        for (int off = 0; off < NUM_LANES; off++) begin
            idx = (int'(rr_reg) + off) % NUM_LANES;
            if (!found && !empty[LANE_W'(idx)]) begin
                found       = 1'b1;
                search_lane = LANE_W'(idx);
            end
        end
    end

    // A locked group pins the grant; a stalled packet keeps its grant so the
    // dispatch outputs stay stable until it fires.
    always_comb begin
        if (state_reg == LOCKED)
            grant = lock_lane_reg;
        else if (hold_reg)
            grant = grant_reg;
        else
            grant = search_lane;
    end

    assign out_valid     = !empty[grant];
    assign fire          = out_valid && bus.out_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? head_data[grant] : '0;
    assign bus.out_lane  = grant;

    // ------------------------------------------------------------------
    // Arbiter / group-lock FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= UNLOCKED;
            rr_reg        <= '0;
            lock_lane_reg <= '0;
            remaining_reg <= '0;
            hold_reg      <= 1'b0;
            grant_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            rr_reg        <= rr_next;
            lock_lane_reg <= lock_lane_next;
            remaining_reg <= remaining_next;
            hold_reg      <= hold_next;
            grant_reg     <= grant_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rr_next        = rr_reg;
        lock_lane_next = lock_lane_reg;
        remaining_next = remaining_reg;
        hold_next      = out_valid && !bus.out_ready;
        grant_next     = grant;
        if (fire) begin
            case (state_reg)
                UNLOCKED: begin
                    if (head_gcnt[grant] == '0) begin
                        rr_next = next_lane(grant);
                    end else begin
                        // rr is left alone; it advances past the lock lane on unlock.
                        state_next     = LOCKED;
                        lock_lane_next = grant;
                        remaining_next = head_gcnt[grant];
                    end
                end
                LOCKED: begin
                    // Group members' own gcnt fields are ignored.
                    remaining_next = remaining_reg - CNT_W'(1);
                    if (remaining_reg == CNT_W'(1)) begin
                        state_next = UNLOCKED;
                        rr_next    = next_lane(lock_lane_reg);
                    end
                end
                default: state_next = UNLOCKED;
            endcase
        end
    end

`ifdef VX_OPERANDS_GATHER_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [31:0]          stalls_reg;
    logic [31:0]          bubbles_reg;
    logic [NUM_LANES-1:0] lock_mask;
    logic                 stall_cond;
    logic                 bubble_cond;

    assign lock_mask   = NUM_LANES'(1) << lock_lane_reg;
    assign stall_cond  = out_valid && !bus.out_ready;
    assign bubble_cond = (state_reg == LOCKED) && empty[lock_lane_reg] &&
                         (|(~empty & ~lock_mask));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stalls_reg  <= '0;
            bubbles_reg <= '0;
        end else begin
            if (stall_cond && (stalls_reg != '1))
                stalls_reg <= stalls_reg + 32'd1;
            if (bubble_cond && (bubbles_reg != '1))
                bubbles_reg <= bubbles_reg + 32'd1;
        end
    end

    assign perf_stalls  = stalls_reg;
    assign perf_bubbles = bubbles_reg;
`endif

endmodule

// File: tb/tb_vx_operands_gather.sv
module tb_vx_operands_gather;
    localparam int NL    = 4;
    localparam int DW    = 512;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int LW    = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    logic [DW+LW:0] got_b;
    logic [DW+LW:0] exp_b;

    logic [DW-1:0] sb_data [NL][$];
    logic [CW-1:0] sb_gcnt [NL][$];

    vx_operands_gather_if #(.NUM_LANES(NL), .DATA_WIDTH(DW), .CNT_W(CW), .LANE_W(LW)) bus ();

`ifdef VX_OPERANDS_GATHER_PERF_EN
    logic [31:0] perf_stalls;
    logic [31:0] perf_bubbles;
`endif

    vx_operands_gather #(
        .NUM_LANES(NL), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CW), .LANE_W(LW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef VX_OPERANDS_GATHER_PERF_EN
        ,
        .perf_stalls  (perf_stalls),
        .perf_bubbles (perf_bubbles)
`endif
    );

    function automatic logic [DW-1:0] pat(input int lane, input int seq);
        logic [31:0] w;
        w = {8'(lane), 24'(seq)};
        return {16{w}};
    endfunction

    function automatic logic [DW+LW:0] beat(input int lane, input logic [DW-1:0] d);
        return {1'b1, LW'(lane), d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int lane, input logic [DW-1:0] d, input logic [CW-1:0] g);
        bus.in_valid[lane]           = 1'b1;
        bus.in_data[lane*DW +: DW]   = d;
        bus.in_gcnt[lane*CW +: CW]   = g;
    endtask

    task automatic clear_in();
        bus.in_valid = '0;
    endtask

    // Compares the whole dispatch beat {valid, lane, data} against expectation.
    `define BEAT_CHECK(NAME, LANE, DATA) \
        assert_cnt++; got_b = {bus.out_valid, bus.out_lane, bus.out_data}; exp_b = beat(LANE, DATA); \
        if (got_b !== exp_b) begin fail_cnt++; \
            $display("FAIL %s: got v/lane=%b data=%h required v/lane=%b data=%h", NAME, \
                     got_b[DW+LW -: LW+1], got_b[31:0], exp_b[DW+LW -: LW+1], exp_b[31:0]); end

    `define IDLE_CHECK(NAME) \
        assert_cnt++; \
        if (bus.out_valid !== 1'b0) begin fail_cnt++; \
            $display("FAIL %s: out_valid got %b required 0", NAME, bus.out_valid); end

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = '0; bus.in_data = '0; bus.in_gcnt = '0; bus.out_ready = 1'b0;
        repeat (2) tick();
        assert_cnt++;
        if ({bus.out_valid, bus.in_ready, bus.out_lane, bus.out_data} !== {1'b1 ^ 1'b1, 4'hF, 2'd0, {DW{1'b0}}}) begin
            fail_cnt++;
            $display("FAIL reset_outputs: got v=%b rdy=%h lane=%0d data=%h required v=0 rdy=f lane=0 data=0",
                     bus.out_valid, bus.in_ready, bus.out_lane, bus.out_data[31:0]);
        end
        reset = 1'b0;
        bus.out_ready = 1'b1;
        push(2, pat(2, 0), 0); push(3, pat(3, 0), 2);
        tick(); clear_in();
        `BEAT_CHECK("t1_lane2", 2, pat(2, 0))
        tick();
        `BEAT_CHECK("t1_lane3_grp", 3, pat(3, 0))
        push(1, pat(1, 0), 0);
        tick(); clear_in();
        `IDLE_CHECK("t1_locked_bubble")
        // Asynchronous reset in the middle of the locked group.
        reset = 1'b1;
        #1;
        assert_cnt++;
        if ({bus.out_valid, bus.in_ready, bus.out_lane} !== {1'b0, 4'hF, 2'd0}) begin
            fail_cnt++;
            $display("FAIL t1_async_reset: got v=%b rdy=%h lane=%0d required v=0 rdy=f lane=0",
                     bus.out_valid, bus.in_ready, bus.out_lane);
        end
        #1 reset = 1'b0;
        push(0, pat(0, 1), 0); push(3, pat(3, 1), 0);
        tick(); clear_in();
        `BEAT_CHECK("t1_rr0_lane0", 0, pat(0, 1))
        tick();
        `BEAT_CHECK("t1_rr0_lane3", 3, pat(3, 1))
        tick();
        `IDLE_CHECK("t1_flushed")
    endtask

    task automatic test_round_robin();
        bus.out_ready = 1'b1;
        for (int k = 0; k < NL; k++) push(k, pat(k, 'h20), 0);
        tick(); clear_in();
        for (int k = 0; k < NL; k++) begin
            `BEAT_CHECK("t2_rr_beat", k, pat(k, 'h20))
            tick();
        end
        `IDLE_CHECK("t2_drained")
    endtask

    task automatic test_group_lock();
        bus.out_ready = 1'b1;
        push(2, pat(2, 'h30), 2);
        tick(); clear_in();
        `BEAT_CHECK("t3_group_head", 2, pat(2, 'h30))
        push(0, pat(0, 'h31), 0); push(1, pat(1, 'h31), 0); push(3, pat(3, 'h31), 0);
        tick(); clear_in();
        `IDLE_CHECK("t3_bubble1")
        tick();
        `IDLE_CHECK("t3_bubble2")
        push(2, pat(2, 'h32), 3);
        tick(); clear_in();
        `BEAT_CHECK("t3_group_b", 2, pat(2, 'h32))
        push(2, pat(2, 'h33), 1);
        tick(); clear_in();
        `BEAT_CHECK("t3_group_c", 2, pat(2, 'h33))
        tick();
        `BEAT_CHECK("t3_after_rr3", 3, pat(3, 'h31))
        tick();
        `BEAT_CHECK("t3_after_lane0", 0, pat(0, 'h31))
        tick();
        `BEAT_CHECK("t3_after_lane1", 1, pat(1, 'h31))
        tick();
        `IDLE_CHECK("t3_drained")
`ifdef VX_OPERANDS_GATHER_PERF_EN
        assert_cnt++;
        if (perf_bubbles !== 32'd2) begin
            fail_cnt++;
            $display("FAIL t3_perf_bubbles: got %0d required 2", perf_bubbles);
        end
`endif
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        push(0, pat(0, 'h40), 0);
        tick(); clear_in();
        for (int i = 0; i < 5; i++) begin
            `BEAT_CHECK("t4_stall_hold", 0, pat(0, 'h40))
            if (i == 0) push(3, pat(3, 'h40), 0);
            tick();
            if (i == 0) clear_in();
        end
        `BEAT_CHECK("t4_stall_end", 0, pat(0, 'h40))
`ifdef VX_OPERANDS_GATHER_PERF_EN
        assert_cnt++;
        if (perf_stalls !== 32'd5) begin
            fail_cnt++;
            $display("FAIL t4_perf_stalls: got %0d required 5", perf_stalls);
        end
`endif
        bus.out_ready = 1'b1;
        tick();
        `BEAT_CHECK("t4_next_lane3", 3, pat(3, 'h40))
        tick();
        `IDLE_CHECK("t4_drained")
    endtask

    task automatic test_full();
        bus.out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            assert_cnt++;
            if (bus.in_ready[1] !== 1'b1) begin
                fail_cnt++;
                $display("FAIL t5_ready_before_push%0d: got %b required 1", k, bus.in_ready[1]);
            end
            push(1, pat(1, 'h50 + k), 0);
            tick(); clear_in();
        end
        assert_cnt++;
        if (bus.in_ready !== 4'b1101) begin
            fail_cnt++;
            $display("FAIL t5_full_ready: got %b required 1101", bus.in_ready);
        end
        `BEAT_CHECK("t5_head0", 1, pat(1, 'h50))
        // Push attempt on the same edge as a pop: the full FIFO must refuse it.
        push(1, pat(1, 'h5f), 0);
        bus.out_ready = 1'b1;
        tick(); clear_in();
        bus.out_ready = 1'b0;
        assert_cnt++;
        if (bus.in_ready[1] !== 1'b1) begin
            fail_cnt++;
            $display("FAIL t5_ready_after_pop: got %b required 1", bus.in_ready[1]);
        end
        `BEAT_CHECK("t5_head1", 1, pat(1, 'h51))
        bus.out_ready = 1'b1;
        tick();
        `BEAT_CHECK("t5_head2", 1, pat(1, 'h52))
        tick();
        `BEAT_CHECK("t5_head3", 1, pat(1, 'h53))
        tick();
        `IDLE_CHECK("t5_refused_push_absent")
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        push(1, pat(1, 'h60), 0);
        tick(); clear_in();
        `BEAT_CHECK("t5b_g0", 1, pat(1, 'h60))
        push(1, pat(1, 'h61), 0);
        tick(); clear_in();
        `BEAT_CHECK("t5b_g1", 1, pat(1, 'h61))
        tick();
        `IDLE_CHECK("t5b_drained")
    endtask

    task automatic test_random();
        int  seq [NL];
        bit  locked;
        int  lock_l;
        int  rem;
        bit  any;
        bit  exp_valid;
        int  lane;
        logic [CW-1:0] g;
        locked = 1'b0; lock_l = 0; rem = 0;
        for (int l = 0; l < NL; l++) seq[l] = 'h1000;
        for (int cyc = 0; cyc < 10200; cyc++) begin
            for (int l = 0; l < NL; l++) begin
                if (cyc < 10000 ? ($urandom_range(0, 99) < 40) : (locked && l == lock_l)) begin
                    push(l, pat(l, seq[l]), (cyc < 10000) ? CW'($urandom_range(0, 3)) : CW'(0));
                    seq[l]++;
                end else begin
                    bus.in_valid[l] = 1'b0;
                end
            end
            bus.out_ready = (cyc >= 10000) ? 1'b1 : ($urandom_range(0, 99) < 60);
            any = 1'b0;
            for (int l = 0; l < NL; l++) begin
                if (sb_data[l].size() != 0) any = 1'b1;
                assert_cnt++;
                if (bus.in_ready[l] !== (sb_data[l].size() < DEPTH)) begin
                    fail_cnt++;
                    $display("FAIL t6_in_ready cyc %0d lane %0d: got %b required %b", cyc, l,
                             bus.in_ready[l], sb_data[l].size() < DEPTH);
                end
            end
            exp_valid = locked ? (sb_data[lock_l].size() != 0) : any;
            assert_cnt++;
            if (bus.out_valid !== exp_valid) begin
                fail_cnt++;
                $display("FAIL t6_out_valid cyc %0d: got %b required %b", cyc, bus.out_valid, exp_valid);
            end
            if (bus.out_valid === 1'b1) begin
                lane = int'(bus.out_lane);
                if (locked) begin
                    assert_cnt++;
                    if (lane != lock_l) begin
                        fail_cnt++;
                        $display("FAIL t6_group_contig cyc %0d: got lane %0d required %0d", cyc, lane, lock_l);
                    end
                end
                assert_cnt++;
                if (sb_data[lane].size() == 0) begin
                    fail_cnt++;
                    $display("FAIL t6_dup cyc %0d: lane %0d issued data %h with nothing queued", cyc, lane,
                             bus.out_data[31:0]);
                end else if (bus.out_data !== sb_data[lane][0]) begin
                    fail_cnt++;
                    $display("FAIL t6_order cyc %0d lane %0d: got %h required %h", cyc, lane,
                             bus.out_data[31:0], sb_data[lane][0][31:0]);
                end else if (bus.out_ready) begin
                    void'(sb_data[lane].pop_front());
                    g = sb_gcnt[lane].pop_front();
                    if (locked) begin
                        rem--;
                        if (rem == 0) locked = 1'b0;
                    end else if (g != '0) begin
                        locked = 1'b1; lock_l = lane; rem = int'(g);
                    end
                end
            end
            for (int l = 0; l < NL; l++) begin
                if (bus.in_valid[l] && bus.in_ready[l]) begin
                    sb_data[l].push_back(bus.in_data[l*DW +: DW]);
                    sb_gcnt[l].push_back(bus.in_gcnt[l*CW +: CW]);
                end
            end
            tick();
        end
        clear_in();
        for (int l = 0; l < NL; l++) begin
            assert_cnt++;
            if (sb_data[l].size() != 0) begin
                fail_cnt++;
                $display("FAIL t6_loss lane %0d: got %0d packets undelivered required 0", l, sb_data[l].size());
            end
        end
        `IDLE_CHECK("t6_final_idle")
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_group_lock();
        test_backpressure();
        test_full();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
